// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared state encoding and reference seeds for the Fibonacci checker
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } fib_chk_state_t;

  localparam int FIB_SEED_A = 0;
  localparam int FIB_SEED_B = 1;
  localparam int DLY_W      = 4;

endpackage

// File: rtl/fib_ref.sv
// rtl/fib_ref.sv - local Fibonacci reference pair (a,b); exp presents a, wraps mod 2^WIDTH
module fib_ref
  import fib_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  output logic [WIDTH-1:0] exp
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a <= WIDTH'(FIB_SEED_A);
      r_b <= WIDTH'(FIB_SEED_B);
    end else if (clr) begin
      r_a <= WIDTH'(FIB_SEED_A);
      r_b <= WIDTH'(FIB_SEED_B);
    end else if (adv) begin
      r_a <= r_b;
      r_b <= r_a + r_b;
    end
  end

  assign exp = r_a;

endmodule

// File: rtl/fib_chk.sv
// rtl/fib_chk.sv - checks synchronized Fibonacci tokens against a local reference and
// returns a two-phase acknowledge per accepted token
module fib_chk
  import fib_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int CNT_W   = 16,
  parameter int N_TOK   = 24,
  parameter int ACK_DLY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic             in_vld,
  output logic             ack_o,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             proto_err,
  output logic [CNT_W-1:0] tok_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] last
);

  fib_chk_state_t   r_state;
  fib_chk_state_t   w_next;
  logic             r_start_q;
  logic [DLY_W-1:0] r_dly;
  logic             r_ack;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_perr;
  logic [CNT_W-1:0] r_tok;
  logic [CNT_W-1:0] r_ecnt;
  logic [WIDTH-1:0] r_last;
  logic             w_rise;
  logic             w_clr;
  logic             w_adv;
  logic             w_toggle;
  logic             w_perr_set;
  logic [WIDTH-1:0] w_exp;

  assign w_rise = start & ~r_start_q;

  fib_ref #(.WIDTH(WIDTH)) u_ref (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .adv (w_adv),
    .exp (w_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_clr      = 1'b0;
    w_adv      = 1'b0;
    w_toggle   = 1'b0;
    w_perr_set = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        // a strobe coinciding with start is still a protocol error, charged to the new run
        w_perr_set = in_vld;
        if (w_rise) begin
          w_next = WAIT;
          w_clr  = 1'b1;
        end
      end
      WAIT: begin
        if (in_vld) begin
          w_adv  = 1'b1;
          w_next = ACK;
        end
      end
      ACK: begin
        w_perr_set = in_vld;
        if (r_dly == DLY_W'(ACK_DLY)) begin
          w_toggle = 1'b1;
          w_next   = (r_tok == CNT_W'(N_TOK)) ? DONE : WAIT;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start_q <= 1'b0;
      r_dly     <= '0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_perr    <= 1'b0;
      r_tok     <= '0;
      r_ecnt    <= '0;
      r_last    <= '0;
    end else begin
      r_start_q <= start;
      r_ack     <= r_ack ^ w_toggle;
      r_busy    <= (w_next == WAIT) || (w_next == ACK);
      r_done    <= (w_next == DONE);
      if (w_adv)                r_dly <= '0;
      else if (r_state == ACK)  r_dly <= r_dly + DLY_W'(1);
      if (w_clr) begin
        r_tok  <= '0;
        r_ecnt <= '0;
        r_err  <= 1'b0;
        r_perr <= w_perr_set;
      end else begin
        if (w_perr_set) r_perr <= 1'b1;
        if (w_adv) begin
          r_last <= in;
          r_tok  <= r_tok + CNT_W'(1);
          if (in != w_exp) begin
            r_err <= 1'b1;
            if (r_ecnt != '1) r_ecnt <= r_ecnt + CNT_W'(1);
          end
        end
      end
    end
  end

  assign ack_o     = r_ack;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign proto_err = r_perr;
  assign tok_cnt   = r_tok;
  assign err_cnt   = r_ecnt;
  assign last      = r_last;

endmodule

// File: tb/tb_fib_chk.sv
// tb/tb_fib_chk.sv - scoreboard bench for fib_chk over four parameter sets
module tb_fib_chk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  start;
  logic [3:0]  vld;
  logic [15:0] din [4];

  wire  [3:0]  ack_w, busy_w, done_w, err_w, perr_w;
  wire  [15:0] tok_w [4];
  wire  [15:0] ecnt_w [4];
  wire  [15:0] last_w [4];

  fib_chk #(.N_TOK(24), .ACK_DLY(2)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .in(din[0]), .in_vld(vld[0]),
    .ack_o(ack_w[0]), .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]),
    .proto_err(perr_w[0]), .tok_cnt(tok_w[0]), .err_cnt(ecnt_w[0]), .last(last_w[0]));
  fib_chk #(.N_TOK(26), .ACK_DLY(0)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .in(din[1]), .in_vld(vld[1]),
    .ack_o(ack_w[1]), .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]),
    .proto_err(perr_w[1]), .tok_cnt(tok_w[1]), .err_cnt(ecnt_w[1]), .last(last_w[1]));
  fib_chk #(.N_TOK(4), .ACK_DLY(3)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .in(din[2]), .in_vld(vld[2]),
    .ack_o(ack_w[2]), .busy(busy_w[2]), .done(done_w[2]), .err(err_w[2]),
    .proto_err(perr_w[2]), .tok_cnt(tok_w[2]), .err_cnt(ecnt_w[2]), .last(last_w[2]));
  fib_chk #(.N_TOK(2), .ACK_DLY(4)) u3 (
    .clk(clk), .rst(rst), .start(start[3]), .in(din[3]), .in_vld(vld[3]),
    .ack_o(ack_w[3]), .busy(busy_w[3]), .done(done_w[3]), .err(err_w[3]),
    .proto_err(perr_w[3]), .tok_cnt(tok_w[3]), .err_cnt(ecnt_w[3]), .last(last_w[3]));

  typedef struct {
    int          k;
    logic [15:0] last;
    int          tok;
    int          ecnt;
    int          err;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   ntot = 0;
  int   nbad = 0;
  int   cyc  = 0;
  int   exp_tok [4];

  logic [15:0] fib_tab [26] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13,
                                16'd21, 16'd34, 16'd55, 16'd89, 16'd144, 16'd233, 16'd377,
                                16'd610, 16'd987, 16'd1597, 16'd2584, 16'd4181, 16'd6765,
                                16'd10946, 16'd17711, 16'd28657, 16'd46368, 16'd9489};

  task automatic chk(input string nm, input int act, input int req);
    ntot++;
    if (act != req) begin
      nbad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  logic prev_ack [4];
  int   prev_tok [4];
  int   cap      [4];
  bit   pend     [4];

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst) begin
        pend[k] = 1'b0;
      end else begin
        if (tok_w[k] != prev_tok[k] && tok_w[k] != 0) begin
          cap[k]  = cyc;
          pend[k] = 1'b1;
        end
        if (ack_w[k] !== prev_ack[k]) begin
          if (sbq.size() == 0) begin
            chk($sformatf("unexpected_toggle_u%0d", k), 1, 0);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_inst", k, e.k);
            chk($sformatf("last_u%0d", k), last_w[k], e.last);
            chk($sformatf("tok_cnt_u%0d", k), tok_w[k], e.tok);
            chk($sformatf("err_cnt_u%0d", k), ecnt_w[k], e.ecnt);
            chk($sformatf("err_u%0d", k), err_w[k], e.err);
            chk($sformatf("ack_latency_u%0d", k), cyc - cap[k], e.lat);
          end
          pend[k] = 1'b0;
        end
        if (pend[k]) chk($sformatf("busy_in_ack_u%0d", k), busy_w[k], 1);
      end
      prev_ack[k] = ack_w[k];
      prev_tok[k] = tok_w[k];
    end
  end

  task automatic do_start(input int k);
    exp_tok[k] = 0;
    @(negedge clk); start[k] = 1'b1;
    @(negedge clk); start[k] = 1'b0;
  endtask

  task automatic send(input int k, input logic [15:0] v, input logic [15:0] el,
                      input int ecnt, input int e, input int lat, input bit extra);
    logic pa;
    exp_t x;
    exp_tok[k]++;
    x = '{k, el, exp_tok[k], ecnt, e, lat};
    sbq.push_back(x);
    @(negedge clk);
    pa     = ack_w[k];
    din[k] = v;
    vld[k] = 1'b1;
    @(negedge clk);
    vld[k] = 1'b0;
    if (extra) begin
      din[k] = 16'hBEEF;
      vld[k] = 1'b1;
      @(negedge clk);
      vld[k] = 1'b0;
    end
    for (int n = 0; n < 40 && ack_w[k] == pa; n++) @(negedge clk);
    chk($sformatf("ack_toggle_seen_u%0d", k), int'(ack_w[k] != pa), 1);
  endtask

  task automatic strobe(input int k, input logic [15:0] v);
    @(negedge clk); din[k] = v; vld[k] = 1'b1;
    @(negedge clk); vld[k] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst   = 1'b0;
    start = '0;
    vld   = '0;
    for (int k = 0; k < 4; k++) din[k] = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("rst_ack", ack_w[k], 0);
      chk("rst_busy", busy_w[k], 0);
      chk("rst_done", done_w[k], 0);
      chk("rst_tok", tok_w[k], 0);
    end
    chk("rst_err", err_w[0], 0);
    chk("rst_perr", perr_w[0], 0);
    chk("rst_ecnt", ecnt_w[0], 0);
    chk("rst_last", last_w[0], 0);
    #2 rst = 1'b1;

    // full 24-token run
    do_start(0);
    chk("t1_busy_after_start", busy_w[0], 1);
    for (int i = 0; i < 24; i++) send(0, fib_tab[i], fib_tab[i], 0, 0, 3, 1'b0);
    repeat (2) @(negedge clk);
    chk("t1_tok", tok_w[0], 24);
    chk("t1_err", err_w[0], 0);
    chk("t1_done", done_w[0], 1);
    chk("t1_busy", busy_w[0], 0);
    chk("t1_ack_end", ack_w[0], 0);
    chk("t1_perr", perr_w[0], 0);

    // mismatch on token 5, then the run continues on the true sequence
    do_start(0);
    chk("t3_tok_cleared", tok_w[0], 0);
    for (int i = 0; i < 4; i++) send(0, fib_tab[i], fib_tab[i], 0, 0, 3, 1'b0);
    send(0, 16'd4, 16'd4, 1, 1, 3, 1'b0);
    send(0, 16'd5, 16'd5, 1, 1, 3, 1'b0);
    send(0, 16'd8, 16'd8, 1, 1, 3, 1'b0);
    chk("t3_err", err_w[0], 1);
    chk("t3_ecnt", ecnt_w[0], 1);
    chk("t3_ack_after7", ack_w[0], 1);

    // reset mid-run after token 7
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("t5_ack", ack_w[0], 0);
    chk("t5_tok", tok_w[0], 0);
    chk("t5_ecnt", ecnt_w[0], 0);
    chk("t5_err", err_w[0], 0);
    chk("t5_last", last_w[0], 0);
    chk("t5_busy", busy_w[0], 0);
    #2 rst = 1'b1;
    do_start(0);
    send(0, 16'd0, 16'd0, 0, 0, 3, 1'b0);
    send(0, 16'd1, 16'd1, 0, 0, 3, 1'b0);
    chk("t5_err_new_run", err_w[0], 0);

    // wrap-around and zero ack delay
    do_start(1);
    for (int i = 0; i < 24; i++) send(1, fib_tab[i], fib_tab[i], 0, 0, 1, 1'b0);
    send(1, 16'd46368, 16'd46368, 0, 0, 1, 1'b0);
    send(1, 16'd9489, 16'd9489, 0, 0, 1, 1'b0);
    repeat (2) @(negedge clk);
    chk("t2_last", last_w[1], 9489);
    chk("t2_err", err_w[1], 0);
    chk("t2_done", done_w[1], 1);
    chk("t2_ack_end", ack_w[1], 0);

    // strobe during ACK, then after done
    do_start(2);
    chk("t4_perr_clear", perr_w[2], 0);
    send(2, 16'd0, 16'd0, 0, 0, 4, 1'b1);
    chk("t4_perr_ack", perr_w[2], 1);
    chk("t4_tok_ack", tok_w[2], 1);
    for (int i = 1; i < 4; i++) send(2, fib_tab[i], fib_tab[i], 0, 0, 4, 1'b0);
    strobe(2, 16'd3);
    repeat (8) @(negedge clk);
    chk("t4_tok_final", tok_w[2], 4);
    chk("t4_ack_final", ack_w[2], 0);
    chk("t4_done", done_w[2], 1);
    chk("t4_perr", perr_w[2], 1);

    // long ack delay, done-state strobe, start coinciding with a strobe
    do_start(3);
    send(3, 16'd0, 16'd0, 0, 0, 5, 1'b0);
    send(3, 16'd1, 16'd1, 0, 0, 5, 1'b0);
    repeat (2) @(negedge clk);
    chk("t6_done", done_w[3], 1);
    chk("t6_perr_before", perr_w[3], 0);
    strobe(3, 16'd1);
    repeat (6) @(negedge clk);
    chk("t6_perr_done", perr_w[3], 1);
    chk("t6_tok_done", tok_w[3], 2);
    chk("t6_ack_done", ack_w[3], 0);
    @(negedge clk);
    start[3] = 1'b1; din[3] = 16'd5; vld[3] = 1'b1;
    @(negedge clk);
    start[3] = 1'b0; vld[3] = 1'b0;
    @(negedge clk);
    chk("t6_start_vld_perr", perr_w[3], 1);
    chk("t6_start_vld_tok", tok_w[3], 0);
    chk("t6_start_vld_busy", busy_w[3], 1);
    chk("t6_start_vld_done", done_w[3], 0);

    repeat (4) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
